// File: rtl/pc_target_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_target_table_if
//  Description : Lookup, table-write and link-stack signals of the PC target
//                table, with master (requester) and slave (table) views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_target_table_if #(
    parameter int D = 12,
    parameter int A = 4
);
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         wr_rel;
    logic         lookup_en;
    logic [A-1:0] lookup_addr;
    logic [D-1:0] pc;
    logic         call;
    logic         ret;
    logic [D-1:0] target;
    logic         target_valid;
    logic         stack_empty;
    logic         stack_full;
    logic         overflow_err;
    logic         underflow_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_rel,
        output lookup_en, lookup_addr, pc, call, ret,
        input  target, target_valid, stack_empty, stack_full,
        input  overflow_err, underflow_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_rel,
        input  lookup_en, lookup_addr, pc, call, ret,
        output target, target_valid, stack_empty, stack_full,
        output overflow_err, underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_target_table.sv
`default_nettype none
// ============================================================================
//  Module      : pc_target_table
//  Description : Writable table of absolute / PC-relative branch targets with
//                a link stack for call/return; target resolves one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_target_table #(
    parameter int D = 12,
    parameter int A = 4,
    parameter int S = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    pc_target_table_if.slave   bus
);
    localparam int              c_N      = 2 ** A;
    localparam int              c_DW     = $clog2(S + 1);
    localparam int              c_IW     = (S > 1) ? $clog2(S) : 1;
    localparam logic [c_DW-1:0] c_FULL   = c_DW'(S);
    localparam logic [c_DW-1:0] c_ONE    = c_DW'(1);
    localparam logic [D-1:0]    c_PC_INC = D'(1);

    logic [D-1:0]    r_val [c_N];
    logic [c_N-1:0]  r_rel;
    logic [D-1:0]    r_stk [2 ** c_IW];
    logic [c_DW-1:0] r_depth;
    logic [D-1:0]    r_target;
    logic            r_valid;
    logic            r_empty;
    logic            r_full;
    logic            r_ovf;
    logic            r_unf;

    logic            w_hit;
    logic [D-1:0]    w_ent_val;
    logic            w_ent_rel;
    logic [D-1:0]    w_resolved;
    logic            w_can_pop;
    logic            w_can_push;
    logic            w_do_pop;
    logic            w_do_push;
    logic [c_DW-1:0] w_depth_nxt;
    logic [c_IW-1:0] w_top_idx;
    logic [c_IW-1:0] w_push_idx;

    // A write to the entry being looked up forwards straight into resolution.
    assign w_hit      = bus.wr_en && (bus.wr_addr == bus.lookup_addr);
    assign w_ent_val  = w_hit ? bus.wr_data : r_val[bus.lookup_addr];
    assign w_ent_rel  = w_hit ? bus.wr_rel  : r_rel[bus.lookup_addr];
    assign w_resolved = w_ent_rel ? (bus.pc + w_ent_val) : w_ent_val;

    assign w_can_pop   = (r_depth != '0);
    assign w_can_push  = (r_depth != c_FULL);
    assign w_do_pop    = bus.ret && w_can_pop;
    assign w_do_push   = !bus.ret && bus.lookup_en && bus.call && w_can_push;
    assign w_depth_nxt = w_do_pop  ? (r_depth - c_ONE) :
                         w_do_push ? (r_depth + c_ONE) : r_depth;
    assign w_top_idx   = c_IW'(r_depth - c_ONE);
    assign w_push_idx  = c_IW'(r_depth);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < c_N; i++) begin
                r_val[i] <= (i == 0) ? D'(1) : '0;
            end
            r_rel <= '0;
        end else if (bus.wr_en) begin
            r_val[bus.wr_addr] <= bus.wr_data;
            r_rel[bus.wr_addr] <= bus.wr_rel;
        end
    end

    // Stack slots are only read below the depth pointer, so they need no reset.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_stk[w_push_idx] <= bus.pc + c_PC_INC;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_target <= '0;
            r_valid  <= 1'b0;
            r_depth  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_depth <= w_depth_nxt;
            r_empty <= (w_depth_nxt == '0);
            r_full  <= (w_depth_nxt == c_FULL);
            if (bus.ret) begin
                r_valid <= w_can_pop;
                if (w_can_pop) begin
                    r_target <= r_stk[w_top_idx];
                end else begin
                    r_unf <= 1'b1;
                end
            end else if (bus.lookup_en) begin
                r_valid  <= 1'b1;
                r_target <= w_resolved;
                if (bus.call && !w_can_push) begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.target        = r_target;
    assign bus.target_valid  = r_valid;
    assign bus.stack_empty   = r_empty;
    assign bus.stack_full    = r_full;
    assign bus.overflow_err  = r_ovf;
    assign bus.underflow_err = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_pc_target_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_target_table
//  Description : Directed stimulus for pc_target_table, checked every cycle
//                against a table/queue model plus hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_target_table;
    localparam int D = 12;
    localparam int A = 4;
    localparam int S = 4;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    pc_target_table_if #(.D(D), .A(A)) bus ();

    pc_target_table #(.D(D), .A(A), .S(S)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Model: plain table arrays plus a queue used as the link stack.
    logic [D-1:0] m_val [2 ** A];
    bit           m_rel [2 ** A];
    logic [D-1:0] m_stk [$];
    logic [D-1:0] m_target;
    bit           m_valid, m_ovf, m_unf;
    bit           m_live = 1'b0;

    initial forever begin
        @(posedge Clk);
        if (Reset_n !== 1'b1) begin
            for (int i = 0; i < 2 ** A; i++) begin
                m_val[i] = (i == 0) ? D'(1) : '0;
                m_rel[i] = 1'b0;
            end
            m_stk.delete();
            m_target = '0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_live   = 1'b1;
        end else begin
            if (bus.wr_en) begin
                m_val[bus.wr_addr] = bus.wr_data;
                m_rel[bus.wr_addr] = bus.wr_rel;
            end
            if (bus.ret) begin
                if (m_stk.size() > 0) begin
                    m_target = m_stk.pop_back();
                    m_valid  = 1'b1;
                end else begin
                    m_valid = 1'b0;
                    m_unf   = 1'b1;
                end
            end else if (bus.lookup_en) begin
                m_valid  = 1'b1;
                m_target = m_rel[bus.lookup_addr] ? bus.pc + m_val[bus.lookup_addr]
                                                  : m_val[bus.lookup_addr];
                if (bus.call) begin
                    if (m_stk.size() == S) m_ovf = 1'b1;
                    else m_stk.push_back(bus.pc + D'(1));
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge Clk);
        if (m_live) begin
            chk("model.target",        bus.target,        m_target);
            chk("model.target_valid",  bus.target_valid,  m_valid);
            chk("model.stack_empty",   bus.stack_empty,   m_stk.size() == 0);
            chk("model.stack_full",    bus.stack_full,    m_stk.size() == S);
            chk("model.overflow_err",  bus.overflow_err,  m_ovf);
            chk("model.underflow_err", bus.underflow_err, m_unf);
        end
    end

    task automatic idle();
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.wr_rel      = 1'b0;
        bus.lookup_en   = 1'b0;
        bus.lookup_addr = '0;
        bus.pc          = '0;
        bus.call        = 1'b0;
        bus.ret         = 1'b0;
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic lookup(input int addr, input int pcv, input bit callv);
        bus.lookup_en   = 1'b1;
        bus.lookup_addr = A'(addr);
        bus.pc          = D'(pcv);
        bus.call        = callv;
        tick();
        idle();
    endtask

    task automatic write(input int addr, input int data, input bit rel);
        bus.wr_en   = 1'b1;
        bus.wr_addr = A'(addr);
        bus.wr_data = D'(data);
        bus.wr_rel  = rel;
        tick();
        idle();
    endtask

    task automatic ret_op();
        bus.ret = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        Reset_n = 1'b0;
        idle();
        repeat (2) tick();
        chk("reset.target",        bus.target,        0);
        chk("reset.target_valid",  bus.target_valid,  0);
        chk("reset.stack_empty",   bus.stack_empty,   1);
        chk("reset.stack_full",    bus.stack_full,    0);
        chk("reset.overflow_err",  bus.overflow_err,  0);
        chk("reset.underflow_err", bus.underflow_err, 0);
        Reset_n = 1'b1;

        lookup(0, 0, 1'b0);
        chk("lookup0.target", bus.target, 1);
        chk("lookup0.valid",  bus.target_valid, 1);
        lookup(5, 0, 1'b0);
        chk("lookup5.target", bus.target, 0);
        tick();
        chk("idle.valid",  bus.target_valid, 0);
        chk("idle.target", bus.target, 0);

        write(3, 54, 1'b0);
        lookup(3, 200, 1'b0);
        chk("abs3.target", bus.target, 54);
        write(4, 12'hFFB, 1'b1);
        lookup(4, 4, 1'b0);
        chk("rel4.wrap", bus.target, 12'hFFF);
        lookup(4, 20, 1'b0);
        chk("rel4.target", bus.target, 15);

        bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 12'd91; bus.wr_rel = 1'b0;
        bus.lookup_en = 1'b1; bus.lookup_addr = 4'd7; bus.pc = 12'd0;
        tick();
        idle();
        chk("collide7.target", bus.target, 91);

        for (int k = 1; k <= 4; k++) lookup(0, 10 * k, 1'b1);
        chk("call4.stack_full", bus.stack_full, 1);
        chk("call4.overflow",   bus.overflow_err, 0);
        lookup(0, 50, 1'b1);
        chk("call5.overflow", bus.overflow_err, 1);
        chk("call5.target",   bus.target, 1);
        ret_op(); chk("ret1.target", bus.target, 41);
        ret_op(); chk("ret2.target", bus.target, 31);
        ret_op(); chk("ret3.target", bus.target, 21);
        ret_op(); chk("ret4.target", bus.target, 11);
        chk("ret4.stack_empty", bus.stack_empty, 1);

        ret_op();
        chk("unf.valid",  bus.target_valid, 0);
        chk("unf.target", bus.target, 11);
        chk("unf.flag",   bus.underflow_err, 1);
        repeat (10) tick();
        chk("unf.sticky", bus.underflow_err, 1);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        chk("rst2.overflow",  bus.overflow_err, 0);
        chk("rst2.underflow", bus.underflow_err, 0);
        chk("rst2.empty",     bus.stack_empty, 1);

        bus.lookup_en = 1'b1; bus.lookup_addr = 4'd0; Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        idle();
        chk("rstmid.valid", bus.target_valid, 0);

        lookup(0, 5, 1'b1);
        lookup(0, 76, 1'b1);
        bus.ret = 1'b1; bus.lookup_en = 1'b1; bus.call = 1'b1;
        bus.lookup_addr = 4'd0; bus.pc = 12'd300;
        tick();
        idle();
        chk("retprio.target", bus.target, 77);
        chk("retprio.valid",  bus.target_valid, 1);
        chk("retprio.empty",  bus.stack_empty, 0);
        ret_op();
        chk("retprio.next",   bus.target, 6);
        chk("retprio.drain",  bus.stack_empty, 1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pc_target_table.md
Name: pc_target_table

Overview:
Programmable branch-target generator for the PC unit. It is the parametrised successor to the fixed 16-entry absolute jump LUT. The block holds a writable table of 2^A targets, each tagged absolute or PC-relative, and returns the resolved D-bit target one cycle after a lookup. A small link stack supports call/return, so subroutine returns no longer need table entries.

Parameters:
D, 12, PC/target width in bits
A, 4, table index width; table holds 2^A entries
S, 4, link-stack depth (entries), S >= 1

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset_n  input  1  synchronous active-low reset, sampled on rising edge of Clk
wr_en  input  1  write table entry this cycle
wr_addr  input  A  entry index to write
wr_data  input  D  entry value (absolute target, or two's-complement offset)
wr_rel  input  1  entry mode: 0 absolute, 1 PC-relative
lookup_en  input  1  request target for lookup_addr
lookup_addr  input  A  entry index to resolve
pc  input  D  current PC, sampled with lookup_en
call  input  1  with lookup_en: also push return address pc+1
ret  input  1  pop link stack and emit it as target
target  output  D  resolved jump target
target_valid  output  1  one-cycle pulse: target is new this cycle
stack_empty  output  1  link stack holds 0 entries
stack_full  output  1  link stack holds S entries
overflow_err  output  1  sticky: a push was dropped because the stack was full
underflow_err  output  1  sticky: ret was issued while the stack was empty

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is synchronous, active-low, and has priority over all other inputs.
- Reset state:
  - entry 0 = 1, absolute; all other entries = 0, absolute.
  - target = 0, target_valid = 0, stack depth 0, stack_empty = 1, stack_full = 0.
  - overflow_err = 0, underflow_err = 0.
- Table write: when wr_en=1, the entry at wr_addr takes {wr_rel, wr_data} at the clock edge.
- Lookup (lookup_en=1, ret=0) in cycle t:
  - In cycle t+1, target_valid=1 and target is the resolved value.
  - Absolute entry: target = value.
  - Relative entry: target = (pc + value) mod 2^D, with value treated as signed D-bit; wrap is silent.
- Write/lookup collision: same address in the same cycle is write-first. The lookup resolves using the new wr_data/wr_rel.
- Call (lookup_en=1, call=1, ret=0):
  - The lookup proceeds as normal.
  - (pc+1) mod 2^D is pushed onto the link stack.
  - If the stack is full: the push is dropped, the stack is unchanged, overflow_err is set, and the lookup still completes.
  - call without lookup_en is ignored.
- Return (ret=1) in cycle t:
  - ret has priority; lookup_en and call are ignored that cycle.
  - Non-empty stack: pop; in t+1, target = popped value and target_valid = 1.
  - Empty stack: no pop; target_valid = 0 in t+1, target holds, underflow_err is set.
- Idle cycle: no lookup_en and no ret gives target_valid = 0 in the next cycle, and target holds its last value.
- Stack: LIFO with depth register 0..S. stack_empty and stack_full are registered and consistent with the depth after each edge.
- Sticky flags: overflow_err and underflow_err are cleared only by reset.
- Reset mid-operation: an in-flight lookup is discarded; target_valid = 0 in the cycle after reset is sampled low.
- Throughput: back-to-back lookups or returns are accepted every cycle; there is no stall.

Test Plan:
- Reset, then lookup_addr=0 -> next cycle target=1, target_valid=1. Lookup addr 5 -> target=0.
- Write entry 3 = 54 absolute, lookup 3 with pc=200 -> target=54. Write entry 4 = 0xFFB (-5) relative, lookup 4 with pc=4 -> target=0xFFF (wrap). Lookup 4 with pc=20 -> target=15.
- Same-cycle write entry 7 = 91 and lookup 7 -> next cycle target=91.
- S=4: five call-lookups with pc=10,20,30,40,50 -> stack_full=1 after the fourth, overflow_err=1 after the fifth. Four rets then yield targets 41,31,21,11, and stack_empty=1.
- ret on an empty stack -> target_valid=0, target unchanged, underflow_err=1 and still set 10 cycles later. Assert Reset_n=0 for one cycle -> all flags 0.
- ret and lookup_en in the same cycle with stack top=77 -> target=77, no push even if call=1, and depth decrements by 1.
